mul16_mac: RTL and testbench



---
 rtl/mul16_mac.sv | 130 +++++++++++++
 tb/tb_mul16_mac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul16_mac.sv
// Pipelined 16x16 unsigned multiply-accumulate with a valid/ready run protocol.
// Build option: define MUL16_MAC_SAT_EN to clamp acc at all-ones on overflow instead of wrapping.

module mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);

  // Shift-add array: one partial product per multiplier bit.
  always_comb begin
    product = '0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) product = product + ({16'b0, a} << i);
    end
  end

endmodule

module mul16_mac (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] acc,
  output logic        ovf
);

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        done_take;

  logic [15:0] a_p0, b_p0;
  logic        last_p0, vld_p0;
  logic [31:0] prod_w;
  logic [31:0] prod_p1;
  logic        last_p1, vld_p1;
  logic [36:0] sum_w;
  logic [35:0] acc_nxt;

  // Raw 37-bit sum; bit 36 is the carry out of the accumulator.
  function automatic logic [36:0] acc_add(input logic [35:0] x, input logic [31:0] p);
    return {1'b0, x} + {5'b0, p};
  endfunction

  // On carry either clamp to all-ones or keep the wrapped value.
  function automatic logic [35:0] acc_limit(input logic [36:0] s);
`ifdef MUL16_MAC_SAT_EN
    return s[36] ? 36'hF_FFFF_FFFF : s[35:0];
`else
    return s[35:0];
`endif
  endfunction

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign done_take = (state == DONE) && out_ready;

  // S1: operand register
  always_ff @(posedge clk) begin
    if (!reset_n) vld_p0 <= 1'b0;
    else          vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0    <= a;
      b_p0    <= b;
      last_p0 <= last;
    end
  end

  mul16 u_mul (
    .a       (a_p0),
    .b       (b_p0),
    .product (prod_w)
  );

  // S2: product register
  always_ff @(posedge clk) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    prod_p1 <= prod_w;
    last_p1 <= last_p0;
  end

  assign sum_w   = acc_add(acc, prod_p1);
  assign acc_nxt = acc_limit(sum_w);

  // S3: accumulator and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (done_take) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (vld_p1) begin
      acc <= acc_nxt;
      ovf <= ovf | sum_w[36];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ACC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (accept && last)   state_nxt = DRAIN;
      DRAIN:   if (vld_p1 && last_p1) state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = ACC;
      default:                       state_nxt = ACC;
    endcase
  end

endmodule

// File: tb/tb_mul16_mac.sv
// Directed, table-driven bench for mul16_mac plus reset and handshake sequences.

module tb_mul16_mac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] acc;
  logic        ovf;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul16_mac dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .ovf       (ovf)
  );

  typedef struct {
    string       name;
    int          n;
    int          len;
    bit          gaps;
    logic [15:0] av[4];
    logic [15:0] bv[4];
    logic [35:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      a        = v.av[i % v.len];
      b        = v.bv[i % v.len];
      last     = (i == v.n - 1);
      check({v.name, " in_ready"}, {35'b0, in_ready}, 36'd1);
      step();
      if (v.gaps && i != v.n - 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    last     = 1'b0;
    check({v.name, " drain in_ready"}, {35'b0, in_ready}, 36'd0);
    check({v.name, " out_valid k"}, {35'b0, out_valid}, 36'd0);
    step();
    check({v.name, " out_valid k+1"}, {35'b0, out_valid}, 36'd0);
    step();
    check({v.name, " out_valid k+2"}, {35'b0, out_valid}, 36'd1);
    check({v.name, " acc"}, acc, v.exp_acc);
    check({v.name, " ovf"}, {35'b0, ovf}, {35'b0, v.exp_ovf});
    for (int h = 0; h < hold; h++) begin
      step();
      check({v.name, " hold out_valid"}, {35'b0, out_valid}, 36'd1);
      check({v.name, " hold in_ready"}, {35'b0, in_ready}, 36'd0);
      check({v.name, " hold acc"}, acc, v.exp_acc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({v.name, " post out_valid"}, {35'b0, out_valid}, 36'd0);
    check({v.name, " post in_ready"}, {35'b0, in_ready}, 36'd1);
    check({v.name, " post acc"}, acc, 36'd0);
    check({v.name, " post ovf"}, {35'b0, ovf}, 36'd0);
  endtask

  initial begin
    vec_t v;
    bit   seen_valid;

    vecs[0] = '{name: "single", n: 1, len: 1, gaps: 1'b0,
                av: '{16'd3, 16'd0, 16'd0, 16'd0}, bv: '{16'd5, 16'd0, 16'd0, 16'd0},
                exp_acc: 36'd15, exp_ovf: 1'b0};
    vecs[1] = '{name: "four", n: 4, len: 4, gaps: 1'b0,
                av: '{16'd1, 16'd3, 16'd5, 16'd7}, bv: '{16'd2, 16'd4, 16'd6, 16'd8},
                exp_acc: 36'd100, exp_ovf: 1'b0};
    vecs[2] = '{name: "gaps", n: 2, len: 2, gaps: 1'b1,
                av: '{16'd2, 16'd3, 16'd0, 16'd0}, bv: '{16'd2, 16'd3, 16'd0, 16'd0},
                exp_acc: 36'd13, exp_ovf: 1'b0};
    vecs[3] = '{name: "max16", n: 16, len: 1, gaps: 1'b0,
                av: '{16'hFFFF, 16'd0, 16'd0, 16'd0}, bv: '{16'hFFFF, 16'd0, 16'd0, 16'd0},
                exp_acc: 36'hF_FFE0_0010, exp_ovf: 1'b0};
`ifdef MUL16_MAC_SAT_EN
    vecs[4] = '{name: "max17", n: 17, len: 1, gaps: 1'b0,
                av: '{16'hFFFF, 16'd0, 16'd0, 16'd0}, bv: '{16'hFFFF, 16'd0, 16'd0, 16'd0},
                exp_acc: 36'hF_FFFF_FFFF, exp_ovf: 1'b1};
`else
    vecs[4] = '{name: "max17", n: 17, len: 1, gaps: 1'b0,
                av: '{16'hFFFF, 16'd0, 16'd0, 16'd0}, bv: '{16'hFFFF, 16'd0, 16'd0, 16'd0},
                exp_acc: 36'h0_FFDE_0011, exp_ovf: 1'b1};
`endif
    vecs[5] = '{name: "mixed", n: 3, len: 3, gaps: 1'b0,
                av: '{16'hFFFF, 16'd0, 16'd1, 16'd0}, bv: '{16'd1, 16'h1234, 16'hFFFF, 16'd0},
                exp_acc: 36'h1_FFFE, exp_ovf: 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    last      = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst in_ready", {35'b0, in_ready}, 36'd1);
    check("rst out_valid", {35'b0, out_valid}, 36'd0);
    check("rst acc", acc, 36'd0);
    check("rst ovf", {35'b0, ovf}, 36'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], (i == 1) ? 5 : 1);
      step();
    end

    // Reset while in DRAIN with two beats still in the pipeline.
    in_valid = 1'b1; a = 16'd1; b = 16'd1; last = 1'b0;
    step();
    a = 16'd2; b = 16'd2; last = 1'b1;
    step();
    in_valid = 1'b0; last = 1'b0;
    check("mid in_ready drain", {35'b0, in_ready}, 36'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid rst acc", acc, 36'd0);
    check("mid rst ovf", {35'b0, ovf}, 36'd0);
    check("mid rst in_ready", {35'b0, in_ready}, 36'd1);
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid no out_valid", {35'b0, seen_valid}, 36'd0);
    check("mid acc quiet", acc, 36'd0);
    v = vecs[0];
    v.name = "after_rst";
    run_vec(v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
